// File: rtl/blowfish_mode_ctrl_if.sv
// Streaming and core-side signal bundle for the Blowfish mode-of-operation controller.
// The master side is the user/core environment; the slave side is the controller.
interface blowfish_mode_ctrl_if #(
  parameter int unsigned BLOCK_W = 128
);
  logic [1:0]         mode;
  logic               encrypt;
  logic [BLOCK_W-1:0] iv;
  logic               iv_load;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_last;
  logic               out_err;
  logic               core_Enable;
  logic               core_Encrypt;
  logic [BLOCK_W-1:0] core_plainText;
  logic [BLOCK_W-1:0] core_cipherText;
  logic               core_cipherReady;

  modport master (
    output mode, encrypt, iv, iv_load, in_valid, in_data, in_last, out_ready,
           core_cipherText, core_cipherReady,
    input  in_ready, out_valid, out_data, out_last, out_err,
           core_Enable, core_Encrypt, core_plainText
  );

  modport slave (
    input  mode, encrypt, iv, iv_load, in_valid, in_data, in_last, out_ready,
           core_cipherText, core_cipherReady,
    output in_ready, out_valid, out_data, out_last, out_err,
           core_Enable, core_Encrypt, core_plainText
  );
endinterface

// File: rtl/blowfish_mode_ctrl.sv
// ECB/CBC/CTR chaining controller in front of a Blowfish core, with IV register,
// valid/ready streaming, per-message chain restart and a core-hang timeout.
module blowfish_mode_ctrl #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                 Clk,
  input logic                 RstN,
  blowfish_mode_ctrl_if.slave bus
);
  localparam int unsigned TcntW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ModeCbc = 2'b01;
  localparam logic [1:0] ModeCtr = 2'b10;
  localparam logic [1:0] ModeRsv = 2'b11;
  localparam logic [CTR_W-1:0] CtrOne = CTR_W'(1);
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] iv_q, iv_d;
  logic [BLOCK_W-1:0] core_in_q, core_in_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic [1:0]         mode_q, mode_d;
  logic               enc_q, enc_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               core_enc_q, core_enc_d;
  logic               done_q, done_d;
  logic               in_ready_q;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [BLOCK_W-1:0] ctr_next;
  logic               accept;

  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    ctr_next = chain_q;
    ctr_next[CTR_W-1:0] = chain_q[CTR_W-1:0] + CtrOne;

    state_d    = state_q;
    blk_d      = blk_q;
    chain_d    = chain_q;
    iv_d       = iv_q;
    core_in_d  = core_in_q;
    out_data_d = out_data_q;
    mode_d     = mode_q;
    enc_d      = enc_q;
    last_d     = last_q;
    err_d      = err_q;
    core_enc_d = core_enc_q;
    done_d     = done_q;
    tcnt_d     = tcnt_q;

    unique case (state_q)
      StIdle: begin
        // Load wins for chain; an accepted block on this edge still reads chain_q.
        if (bus.iv_load) begin
          iv_d    = bus.iv;
          chain_d = bus.iv;
        end
        if (accept) begin
          blk_d      = bus.in_data;
          mode_d     = bus.mode;
          enc_d      = bus.encrypt;
          last_d     = bus.in_last;
          core_enc_d = (bus.mode == ModeCtr) | bus.encrypt;
          tcnt_d     = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          unique case (bus.mode)
            ModeCbc: core_in_d = bus.encrypt ? (bus.in_data ^ chain_q) : bus.in_data;
            ModeCtr: core_in_d = chain_q;
            default: core_in_d = bus.in_data;
          endcase
          if (bus.mode == ModeRsv) begin
            state_d    = StOut;
            err_d      = 1'b1;
            out_data_d = '0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        tcnt_d = tcnt_q + TcntW'(1);
        // Result is captured on the ready edge; Enable drops one edge later.
        if (done_q) begin
          state_d = StOut;
        end else if (bus.core_cipherReady) begin
          done_d = 1'b1;
          unique case (mode_q)
            ModeCbc: begin
              out_data_d = enc_q ? bus.core_cipherText : (bus.core_cipherText ^ chain_q);
              chain_d    = enc_q ? bus.core_cipherText : blk_q;
            end
            ModeCtr: begin
              out_data_d = bus.core_cipherText ^ blk_q;
              chain_d    = ctr_next;
            end
            default: out_data_d = bus.core_cipherText;
          endcase
        end else if (tcnt_q == TcntLast) begin
          state_d    = StOut;
          err_d      = 1'b1;
          out_data_d = '0;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
          if (last_q) chain_d = iv_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      chain_q    <= '0;
      iv_q       <= '0;
      core_in_q  <= '0;
      out_data_q <= '0;
      mode_q     <= '0;
      enc_q      <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      core_enc_q <= 1'b0;
      done_q     <= 1'b0;
      tcnt_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      chain_q    <= chain_d;
      iv_q       <= iv_d;
      core_in_q  <= core_in_d;
      out_data_q <= out_data_d;
      mode_q     <= mode_d;
      enc_q      <= enc_d;
      last_q     <= last_d;
      err_q      <= err_d;
      core_enc_q <= core_enc_d;
      done_q     <= done_d;
      tcnt_q     <= tcnt_d;
      in_ready_q <= (state_d == StIdle);
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state_q == StOut);
  assign bus.out_data       = out_data_q;
  assign bus.out_last       = last_q;
  assign bus.out_err        = err_q;
  assign bus.core_Enable    = (state_q == StRun);
  assign bus.core_Encrypt   = core_enc_q;
  assign bus.core_plainText = core_in_q;
endmodule

// File: tb/tb_blowfish_mode_ctrl.sv
// Directed bench for blowfish_mode_ctrl with an XOR stub core that readies on its 3rd Enable cycle.
module tb_blowfish_mode_ctrl;
  localparam int unsigned BW = 128;
  localparam logic [BW-1:0] K = {16{8'hA5}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hang = 1'b0;
  logic [2:0] stub_cnt;
  logic stub_rdy;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  blowfish_mode_ctrl_if #(.BLOCK_W(BW)) bus ();

  blowfish_mode_ctrl #(.BLOCK_W(BW), .CTR_W(32), .TIMEOUT(16)) dut (
    .Clk (clk),
    .RstN(rst_n),
    .bus (bus)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt <= '0;
      stub_rdy <= 1'b0;
    end else if (bus.core_Enable) begin
      if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
      stub_rdy <= (stub_cnt == 3'd2) && !hang;
    end else begin
      stub_cnt <= '0;
      stub_rdy <= 1'b0;
    end
  end

  assign bus.core_cipherReady = stub_rdy & bus.core_Enable;
  assign bus.core_cipherText  = bus.core_plainText ^ K;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_iv(input logic [BW-1:0] v);
    bus.iv      = v;
    bus.iv_load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iv_load = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic enc, input logic [BW-1:0] d,
                      input logic last);
    int g = 0;
    while (!bus.in_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 1'b0, 1'b1);
    bus.mode     = m;
    bus.encrypt  = enc;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Starts at the negedge after the accept edge; lat counts edges until out_valid is seen.
  task automatic wait_out(output int lat, output logic en_seen, output logic enc_seen);
    lat = 0;
    en_seen = 1'b0;
    enc_seen = 1'b0;
    while (!bus.out_valid && lat < 60) begin
      if (bus.core_Enable) begin
        en_seen = 1'b1;
        enc_seen = bus.core_Encrypt;
      end
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [1:0] m, input logic enc, input logic [BW-1:0] d,
                           input logic last, output logic [BW-1:0] q, output logic err,
                           output int lat, output logic en_seen, output logic enc_seen);
    send(m, enc, d, last);
    wait_out(lat, en_seen, enc_seen);
    q   = bus.out_data;
    err = bus.out_err;
    check("en_low_in_out", bus.core_Enable, 1'b0);
    check("out_last", bus.out_last, last);
    drain();
  endtask

  initial begin
    logic [BW-1:0] q;
    logic [BW-1:0] held;
    logic err, en_seen, enc_seen;
    int lat;

    bus.mode = 2'b00; bus.encrypt = 1'b0; bus.iv = '0; bus.iv_load = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_core_en", bus.core_Enable, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1'b1);

    // ECB encrypt
    run_block(2'b00, 1'b1, 128'h1, 1'b0, q, err, lat, en_seen, enc_seen);
    check("ecb_data", q, K ^ 128'h1);
    check("ecb_lat", lat, 5);
    check("ecb_err", err, 1'b0);
    check("ecb_core_enc", enc_seen, 1'b1);
    // ECB decrypt drives core direction low
    run_block(2'b00, 1'b0, 128'h1, 1'b0, q, err, lat, en_seen, enc_seen);
    check("ecb_dec_core_enc", enc_seen, 1'b0);

    // CBC encrypt with restart on last
    load_iv(128'h0F);
    run_block(2'b01, 1'b1, 128'h1, 1'b0, q, err, lat, en_seen, enc_seen);
    check("cbc_enc_b1", q, K ^ 128'h0E);
    run_block(2'b01, 1'b1, 128'h1, 1'b1, q, err, lat, en_seen, enc_seen);
    check("cbc_enc_b2", q, 128'h0F);
    run_block(2'b01, 1'b1, 128'h1, 1'b0, q, err, lat, en_seen, enc_seen);
    check("cbc_enc_b3", q, K ^ 128'h0E);

    // CBC decrypt
    load_iv(128'h0F);
    run_block(2'b01, 1'b0, K ^ 128'h0E, 1'b0, q, err, lat, en_seen, enc_seen);
    check("cbc_dec_b1", q, 128'h1);
    run_block(2'b01, 1'b0, 128'h0F, 1'b1, q, err, lat, en_seen, enc_seen);
    check("cbc_dec_b2", q, 128'h1);

    // CTR, low 32 bits wrap; encrypt=0 must be overridden
    load_iv(128'hFFFF_FFFF);
    run_block(2'b10, 1'b0, '0, 1'b0, q, err, lat, en_seen, enc_seen);
    check("ctr_b1", q, K ^ 128'hFFFF_FFFF);
    check("ctr_core_enc", enc_seen, 1'b1);
    run_block(2'b10, 1'b0, '0, 1'b1, q, err, lat, en_seen, enc_seen);
    check("ctr_wrap", q, K);
    // CTR with nonzero upper bits: carry must not leave the 32-bit field
    load_iv(128'h1_FFFF_FFFF);
    run_block(2'b10, 1'b1, '0, 1'b0, q, err, lat, en_seen, enc_seen);
    check("ctr_hi_b1", q, K ^ 128'h1_FFFF_FFFF);
    run_block(2'b10, 1'b1, 128'h3, 1'b1, q, err, lat, en_seen, enc_seen);
    check("ctr_hi_b2", q, K ^ 128'h1_0000_0000 ^ 128'h3);

    // Timeout in CTR leaves the counter untouched
    hang = 1'b1;
    run_block(2'b10, 1'b1, '0, 1'b0, q, err, lat, en_seen, enc_seen);
    check("tmo_err", err, 1'b1);
    check("tmo_data", q, '0);
    check("tmo_lat", lat, 16);
    hang = 1'b0;
    run_block(2'b10, 1'b1, '0, 1'b1, q, err, lat, en_seen, enc_seen);
    check("tmo_chain_kept", q, K ^ 128'h1_FFFF_FFFF);
    check("after_tmo_err", err, 1'b0);

    // Reserved mode: immediate error, core never enabled
    run_block(2'b11, 1'b1, 128'h55, 1'b0, q, err, lat, en_seen, enc_seen);
    check("rsv_err", err, 1'b1);
    check("rsv_data", q, '0);
    check("rsv_no_enable", en_seen, 1'b0);

    // Output backpressure
    send(2'b00, 1'b1, 128'h22, 1'b1);
    wait_out(lat, en_seen, enc_seen);
    held = bus.out_data;
    check("bp_data0", held, K ^ 128'h22);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1'b1);
      check("bp_data", bus.out_data, K ^ 128'h22);
      check("bp_last", bus.out_last, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    drain();

    // Asynchronous reset mid-RUN
    send(2'b00, 1'b1, 128'h7, 1'b0);
    @(negedge clk);
    check("pre_rst_en", bus.core_Enable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_core_en", bus.core_Enable, 1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_data", bus.out_data, '0);
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_core_pt", bus.core_plainText, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(2'b00, 1'b1, 128'h1, 1'b0, q, err, lat, en_seen, enc_seen);
    check("post_rst_data", q, K ^ 128'h1);
    check("post_rst_lat", lat, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
